spoon_uart_tx: RTL

//  Serialises the pointing-device bytestream (device ID + 3-byte frames) into an

---
 rtl/spoon_uart_tx_if.sv | 15 +
 rtl/spoon_uart_tx.sv | 126 ++++++++++++
 2 files changed

// File: rtl/spoon_uart_tx_if.sv
// Byte-stream side of spoon_uart_tx: upstream write strobe/data in,
// FIFO occupancy and drop indication back out.
interface spoon_uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    in_data;
  logic          in_write;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport master (output in_data, in_write, input fifo_level, overflow);
  modport slave  (input in_data, in_write, output fifo_level, overflow);
endinterface

// File: rtl/spoon_uart_tx.sv
// 8N1 serialiser for the pointing-device bytestream: small byte FIFO feeding
// an LSB-first shifter at a per-frame latched baud divisor, flushed by RTS.
module spoon_uart_tx #(
  parameter int unsigned BIT_TICKS    = 25000,
  parameter int unsigned BIT_TICKS_OC = 20000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            overclock,
  input  logic            rts,
  output logic            txd,
  output logic            busy,
  spoon_uart_tx_if.slave  bus
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned DMAX = (BIT_TICKS > BIT_TICKS_OC) ? BIT_TICKS : BIT_TICKS_OC;
  localparam int unsigned CW   = $clog2(DMAX);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_tick, r_div_m1;
  logic          r_overflow;

  logic w_empty, w_full, w_bit_end, w_pop, w_push, w_txd;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  // Divisor is stored minus one so the full count fits in CW bits.
  assign w_bit_end = (r_tick == r_div_m1);
  assign w_push    = bus.in_write && !rts && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (rts) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (!w_empty) w_next = S_START;
        S_START: if (w_bit_end) w_next = S_DATA;
        S_DATA:  if (w_bit_end && r_bit == 3'd7) w_next = S_STOP;
        S_STOP:  if (w_bit_end) w_next = w_empty ? S_IDLE : S_START;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_txd = 1'b1;
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = !w_empty;
      S_START: w_txd = 1'b0;
      S_DATA:  w_txd = r_shift[0];
      S_STOP:  w_pop = w_bit_end && !w_empty;
      default: w_txd = 1'b1;
    endcase
    if (rts) w_pop = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick   <= '0;
      r_div_m1 <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
    end else if (rts) begin
      r_tick <= '0;
      r_bit  <= '0;
    end else if (w_pop) begin
      r_tick   <= '0;
      r_div_m1 <= overclock ? CW'(BIT_TICKS_OC - 1) : CW'(BIT_TICKS - 1);
      r_shift  <= r_mem[r_rd_ptr];
      r_bit    <= '0;
    end else if (r_state != S_IDLE) begin
      r_tick <= w_bit_end ? '0 : r_tick + 1'b1;
      if (r_state == S_DATA && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.in_write && !rts && w_full && !w_pop;
      if (rts) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_level <= r_level + 1'b1;
        else if (w_pop && !w_push) r_level <= r_level - 1'b1;
      end
    end
  end

  // Full-FIFO push alongside a pop lands on the slot being read this edge.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  assign txd            = w_txd;
  assign busy           = (r_state != S_IDLE) || (r_level != '0);
  assign bus.fifo_level = r_level;
  assign bus.overflow   = r_overflow;
endmodule
